smi_dir_turnaround: RTL and testbench

Direction-turnaround controller for the SMI data bus. It sits directly downstream of the raw SMI direction strobe (address line A2) and the pin synchronizer. It glitch-filters the requested direction, then runs a break-before-make sequence so the FPGA never drives the bus while the host is still driving it. Its outputs gate the SMI data pad output enables and the RX/TX sample paths, and include diagnostic counters for the register file.

---
 rtl/smi_dir_turnaround_if.sv | 48 ++++
 rtl/smi_dir_turnaround.sv | 205 ++++++++++++++++++++
 tb/tb_smi_dir_turnaround.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/smi_dir_turnaround_if.sv
// SMI direction-turnaround bus bundle: raw direction pin in, gated enables and diagnostics out.
// Latency: none (wires only); the controller registers every output it drives here.
// Backpressure: none; the pin is a level and the outputs are levels, pulses and counters.
//
// Signals:
//   i_dir_raw     pin-side async direction request (1 = FPGA drives, 0 = host drives)
//   o_dir         accepted direction
//   o_rx_en       receive path enabled / pads tristated
//   o_tx_en       FPGA drives the data pads
//   o_busy        controller not in its steady state
//   o_dir_changed one-cycle pulse per committed direction change
//   o_glitch_cnt  rejected requests, saturating
//   o_change_cnt  committed changes, wrapping
// master = pin/host side and register-file consumer, slave = the turnaround controller.
interface smi_dir_turnaround_if #(
    parameter int CNT_W = 16
);
    logic             i_dir_raw;
    logic             o_dir;
    logic             o_rx_en;
    logic             o_tx_en;
    logic             o_busy;
    logic             o_dir_changed;
    logic [CNT_W-1:0] o_glitch_cnt;
    logic [CNT_W-1:0] o_change_cnt;

    modport master (
        output i_dir_raw,
        input  o_dir,
        input  o_rx_en,
        input  o_tx_en,
        input  o_busy,
        input  o_dir_changed,
        input  o_glitch_cnt,
        input  o_change_cnt
    );

    modport slave (
        input  i_dir_raw,
        output o_dir,
        output o_rx_en,
        output o_tx_en,
        output o_busy,
        output o_dir_changed,
        output o_glitch_cnt,
        output o_change_cnt
    );
endinterface

// File: rtl/smi_dir_turnaround.sv
// Glitch-filtered, break-before-make direction turnaround for the SMI data pads.
// Latency: pin edge to enables dropping is 1+FILTER_CYCLES edges, new direction after GUARD_CYCLES more.
// Backpressure: none; a direction request that reverts during the guard window still completes.
//
// Ports:
//   i_sys_clk  system clock
//   i_rst_b    asynchronous active-low reset
//   smi        slave side of smi_dir_turnaround_if (raw pin in, enables/status/counters out)
module smi_dir_turnaround #(
    parameter int FILTER_CYCLES = 8,
    parameter int GUARD_CYCLES  = 4,
    parameter int CNT_W         = 16
) (
    input  logic                   i_sys_clk,
    input  logic                   i_rst_b,
    smi_dir_turnaround_if.slave    smi
);

    // One counter serves both the qualification window and the guard windows,
    // since only one of them is ever running.
    localparam int MAXC = (FILTER_CYCLES > GUARD_CYCLES) ? FILTER_CYCLES : GUARD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] F_LAST = CW'(FILTER_CYCLES - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        GUARD_INIT = 2'd0,
        STABLE     = 2'd1,
        QUALIFY    = 2'd2,
        DRAIN      = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             sync1_q, sync2_q;
    logic             mismatch;

    logic             dir_q, dir_d;
    logic             rx_en_q, rx_en_d;
    logic             tx_en_q, tx_en_d;
    logic             busy_q, busy_d;
    logic             chg_q, chg_d;
    logic [CNT_W-1:0] glitch_q, glitch_d;
    logic [CNT_W-1:0] change_q, change_d;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= smi.i_dir_raw;
            sync2_q <= sync1_q;
        end
    end

    assign mismatch = (sync2_q != dir_q);

    // State register.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q <= GUARD_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            GUARD_INIT: begin
                if (cnt_q == G_LAST) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE: begin
                if (mismatch) begin
                    // With a one-cycle filter the first mismatching cycle already qualifies.
                    if (FILTER_CYCLES == 1) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        state_d = QUALIFY;
                        cnt_d   = CW'(1);
                    end
                end
            end
            QUALIFY: begin
                if (!mismatch) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == F_LAST) begin
                    // This edge is the one on which the count reaches FILTER_CYCLES.
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                // The pin is deliberately ignored here: the change is committed.
                if (cnt_q == G_LAST) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = GUARD_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: next values of the registered outputs, keyed on the transition taken.
    always_comb begin
        dir_d    = dir_q;
        rx_en_d  = rx_en_q;
        tx_en_d  = tx_en_q;
        chg_d    = 1'b0;
        glitch_d = glitch_q;
        change_d = change_q;
        busy_d   = (state_d != STABLE);
        unique case (state_q)
            GUARD_INIT: begin
                if (state_d == STABLE) begin
                    rx_en_d = ~dir_q;
                    tx_en_d = dir_q;
                end
            end
            STABLE: begin
                if (state_d == DRAIN) begin
                    rx_en_d = 1'b0;
                    tx_en_d = 1'b0;
                end
            end
            QUALIFY: begin
                if (state_d == STABLE) begin
                    if (glitch_q != {CNT_W{1'b1}}) begin
                        glitch_d = glitch_q + 1'b1;
                    end
                end else if (state_d == DRAIN) begin
                    rx_en_d = 1'b0;
                    tx_en_d = 1'b0;
                end
            end
            DRAIN: begin
                if (state_d == STABLE) begin
                    dir_d    = ~dir_q;
                    rx_en_d  = dir_q;
                    tx_en_d  = ~dir_q;
                    chg_d    = 1'b1;
                    change_d = change_q + 1'b1;
                end
            end
            default: begin
                rx_en_d = 1'b0;
                tx_en_d = 1'b0;
            end
        endcase
    end

    // Output registers. Both enables reset low so the pads are never driven
    // against the host while reset is asserted or just released.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            dir_q    <= 1'b0;
            rx_en_q  <= 1'b0;
            tx_en_q  <= 1'b0;
            busy_q   <= 1'b1;
            chg_q    <= 1'b0;
            glitch_q <= '0;
            change_q <= '0;
        end else begin
            dir_q    <= dir_d;
            rx_en_q  <= rx_en_d;
            tx_en_q  <= tx_en_d;
            busy_q   <= busy_d;
            chg_q    <= chg_d;
            glitch_q <= glitch_d;
            change_q <= change_d;
        end
    end

    assign smi.o_dir         = dir_q;
    assign smi.o_rx_en       = rx_en_q;
    assign smi.o_tx_en       = tx_en_q;
    assign smi.o_busy        = busy_q;
    assign smi.o_dir_changed = chg_q;
    assign smi.o_glitch_cnt  = glitch_q;
    assign smi.o_change_cnt  = change_q;

    // Bus contention guard: receive and transmit must never be enabled together.
    a_no_contention: assert property (@(posedge i_sys_clk) !(rx_en_q && tx_en_q));

endmodule

// File: tb/tb_smi_dir_turnaround.sv
// Bench for smi_dir_turnaround: instance A uses default timing, instance B a short
// filter/guard and 4-bit counters so wrap and saturation are reachable quickly.
// A timestamp-based reference model feeds a per-cycle expectation queue.
module tb_smi_dir_turnaround;

    logic       clk   = 1'b0;
    logic       rst_b = 1'b1;
    logic [1:0] raw   = 2'b00;
    int         edge_n = 0;
    int         total  = 0;
    int         bad    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    smi_dir_turnaround_if #(.CNT_W(16)) bus_a ();
    smi_dir_turnaround_if #(.CNT_W(4))  bus_b ();

    assign bus_a.i_dir_raw = raw[0];
    assign bus_b.i_dir_raw = raw[1];

    smi_dir_turnaround #(.FILTER_CYCLES(8), .GUARD_CYCLES(4), .CNT_W(16)) dut_a (
        .i_sys_clk (clk),
        .i_rst_b   (rst_b),
        .smi       (bus_a.slave)
    );

    smi_dir_turnaround #(.FILTER_CYCLES(2), .GUARD_CYCLES(1), .CNT_W(4)) dut_b (
        .i_sys_clk (clk),
        .i_rst_b   (rst_b),
        .smi       (bus_b.slave)
    );

    // ---------------- reference model ----------------
    localparam int M_INIT = 0, M_STABLE = 1, M_QUAL = 2, M_DRAIN = 3;

    typedef struct {
        int mode;
        int t_mark;   // edge number at which the current timed window started
        bit s1, s2;
        bit dir, rx, tx, chg;
        int gcnt, ccnt;
    } mstate_t;

    typedef struct {
        bit dir, rx, tx, busy, chg;
        int gcnt, ccnt;
    } exp_t;

    int      FP [2] = '{8, 2};
    int      GP [2] = '{4, 1};
    int      WP [2] = '{16, 4};
    mstate_t ms [2];
    exp_t    q0 [$];
    exp_t    q1 [$];
    exp_t    cur [2];
    int      mn = 0;

    function automatic mstate_t m_reset();
        mstate_t r;
        r.mode = M_INIT; r.t_mark = 0; r.s1 = 0; r.s2 = 0;
        r.dir = 0; r.rx = 0; r.tx = 0; r.chg = 0; r.gcnt = 0; r.ccnt = 0;
        return r;
    endfunction

    function automatic exp_t e_reset();
        exp_t e;
        e.dir = 0; e.rx = 0; e.tx = 0; e.busy = 1; e.chg = 0; e.gcnt = 0; e.ccnt = 0;
        return e;
    endfunction

    // One clock edge (number n since reset release) of the specified behaviour.
    function automatic mstate_t m_step(mstate_t m, bit pin, int n, int F, int G, int W);
        mstate_t r = m;
        bit sync = m.s2;
        r.chg = 0;
        r.s1  = pin;
        r.s2  = m.s1;
        case (m.mode)
            M_INIT: if (n - m.t_mark == G) begin
                r.mode = M_STABLE; r.rx = !m.dir; r.tx = m.dir;
            end
            M_STABLE: if (sync != m.dir) begin
                r.t_mark = n;
                if (F == 1) begin r.mode = M_DRAIN; r.rx = 0; r.tx = 0; end
                else r.mode = M_QUAL;
            end
            M_QUAL: begin
                if (sync == m.dir) begin
                    r.mode = M_STABLE;
                    if (m.gcnt < (1 << W) - 1) r.gcnt = m.gcnt + 1;
                end else if (n - m.t_mark + 1 == F) begin
                    r.mode = M_DRAIN; r.t_mark = n; r.rx = 0; r.tx = 0;
                end
            end
            default: if (n - m.t_mark == G) begin
                r.mode = M_STABLE; r.dir = !m.dir; r.rx = m.dir; r.tx = !m.dir;
                r.chg = 1; r.ccnt = (m.ccnt + 1) % (1 << W);
            end
        endcase
        return r;
    endfunction

    function automatic exp_t m_out(mstate_t m);
        exp_t e;
        e.dir = m.dir; e.rx = m.rx; e.tx = m.tx; e.busy = (m.mode != M_STABLE);
        e.chg = m.chg; e.gcnt = m.gcnt; e.ccnt = m.ccnt;
        return e;
    endfunction

    // Stimulus side of the scoreboard: every edge pushes the expected outputs.
    initial begin
        ms[0] = m_reset(); ms[1] = m_reset();
        forever begin
            @(posedge clk or negedge rst_b);
            if (!rst_b) begin
                ms[0] = m_reset(); ms[1] = m_reset(); mn = 0;
                q0.delete(); q1.delete();
            end else begin
                mn++;
                for (int i = 0; i < 2; i++) ms[i] = m_step(ms[i], raw[i], mn, FP[i], GP[i], WP[i]);
                q0.push_back(m_out(ms[0]));
                q1.push_back(m_out(ms[1]));
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(string nm, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic exp_t act_of(int i);
        exp_t a;
        if (i == 0) begin
            a.dir = bus_a.o_dir; a.rx = bus_a.o_rx_en; a.tx = bus_a.o_tx_en;
            a.busy = bus_a.o_busy; a.chg = bus_a.o_dir_changed;
            a.gcnt = int'(bus_a.o_glitch_cnt); a.ccnt = int'(bus_a.o_change_cnt);
        end else begin
            a.dir = bus_b.o_dir; a.rx = bus_b.o_rx_en; a.tx = bus_b.o_tx_en;
            a.busy = bus_b.o_busy; a.chg = bus_b.o_dir_changed;
            a.gcnt = int'({12'b0, bus_b.o_glitch_cnt}); a.ccnt = int'({12'b0, bus_b.o_change_cnt});
        end
        return a;
    endfunction

    task automatic cmp_all(string tag, exp_t a, exp_t e);
        chk({tag, ".dir"},  int'(a.dir),  int'(e.dir));
        chk({tag, ".rx"},   int'(a.rx),   int'(e.rx));
        chk({tag, ".tx"},   int'(a.tx),   int'(e.tx));
        chk({tag, ".busy"}, int'(a.busy), int'(e.busy));
        chk({tag, ".chg"},  int'(a.chg),  int'(e.chg));
        chk({tag, ".gcnt"}, a.gcnt, e.gcnt);
        chk({tag, ".ccnt"}, a.ccnt, e.ccnt);
        chk({tag, ".no_contention"}, int'(a.rx & a.tx), 0);
    endtask

    // Monitor side: pops the expectation for the edge just taken and compares.
    initial begin
        cur[0] = e_reset(); cur[1] = e_reset();
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                cur[0] = e_reset(); cur[1] = e_reset();
            end else begin
                if (q0.size() > 0) cur[0] = q0.pop_front();
                if (q1.size() > 0) cur[1] = q1.pop_front();
            end
            cmp_all("sb_a", act_of(0), cur[0]);
            cmp_all("sb_b", act_of(1), cur[1]);
        end
    end

    // ---------------- directed helpers (instance A) ----------------
    localparam int S_RX = 0, S_TX = 1, S_DIR = 2;

    function automatic bit sig_a(int sel);
        case (sel)
            S_RX:    return bus_a.o_rx_en;
            S_TX:    return bus_a.o_tx_en;
            default: return bus_a.o_dir;
        endcase
    endfunction

    // Returns the edge number at which the signal first shows val, or -1000 on timeout.
    task automatic wait_for(input int sel, input bit val, input int max_cyc, output int at);
        at = -1000;
        for (int c = 0; c < max_cyc; c++) begin
            @(posedge clk); #1;
            if (sig_a(sel) == val) begin
                at = edge_n;
                break;
            end
        end
        if (at < 0) $display("FAIL wait_sel%0d: got timeout expected level %0d", sel, val);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int at, e_idx, rel, busy_n, rxlow_n, chg_n, rise;

        #2 rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_b = 1'b1;
        rel = edge_n;

        // Reset release: rx enable after GUARD_CYCLES edges, no counting.
        wait_for(S_RX, 1, 20, at);
        chk("rel.rx_rise_delay", at - rel, 4);
        chk("rel.tx", int'(bus_a.o_tx_en), 0);
        chk("rel.busy", int'(bus_a.o_busy), 0);
        chk("rel.ccnt", int'(bus_a.o_change_cnt), 0);
        chk("rel.gcnt", int'(bus_a.o_glitch_cnt), 0);
        repeat (3) @(posedge clk);

        // Accepted 0 -> 1 change.
        @(posedge clk); #1 raw[0] = 1'b1; e_idx = edge_n + 1;
        wait_for(S_RX, 0, 40, at);
        chk("t2.rx_fall_delay", at - e_idx, 9);
        wait_for(S_DIR, 1, 40, at);
        chk("t2.dir_delay", at - e_idx, 13);
        chk("t2.tx", int'(bus_a.o_tx_en), 1);
        chk("t2.pulse", int'(bus_a.o_dir_changed), 1);
        chk("t2.ccnt", int'(bus_a.o_change_cnt), 1);
        @(posedge clk); #1;
        chk("t2.pulse_end", int'(bus_a.o_dir_changed), 0);

        // Back to 0.
        raw[0] = 1'b0;
        wait_for(S_DIR, 0, 40, at);
        chk("t2b.ccnt", int'(bus_a.o_change_cnt), 2);
        repeat (4) @(posedge clk);

        // Five-cycle pulse: rejected, busy only while qualifying.
        @(posedge clk); #1 raw[0] = 1'b1;
        busy_n = 0; rxlow_n = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (c == 4) raw[0] = 1'b0;
            busy_n  += int'(bus_a.o_busy);
            rxlow_n += int'(!bus_a.o_rx_en);
        end
        chk("t3.busy_cycles", busy_n, 5);
        chk("t3.rx_low_cycles", rxlow_n, 0);
        chk("t3.gcnt", int'(bus_a.o_glitch_cnt), 1);
        chk("t3.dir", int'(bus_a.o_dir), 0);

        // Pin reverts three cycles into the guard window: change completes, then requalifies.
        @(posedge clk); #1 raw[0] = 1'b1; e_idx = edge_n + 1;
        wait_for(S_RX, 0, 40, at);
        repeat (2) @(posedge clk);
        #1 raw[0] = 1'b0;
        wait_for(S_DIR, 1, 40, at);
        chk("t4.dir1_delay", at - e_idx, 13);
        wait_for(S_DIR, 0, 60, at);
        chk("t4.dir0_delay", at - e_idx, 25);
        chk("t4.ccnt", int'(bus_a.o_change_cnt), 4);

        // Instance B directed saturation/wrap, instance A random, concurrently.
        fork
            begin
                for (int g = 0; g < 20; g++) begin
                    @(posedge clk); #1 raw[1] = 1'b1;
                    @(posedge clk); #1 raw[1] = 1'b0;
                    repeat (4) @(posedge clk);
                end
                repeat (4) @(posedge clk); #1;
                chk("b.gcnt_saturated", int'(bus_b.o_glitch_cnt), 15);
                for (int t = 0; t < 21; t++) begin
                    @(posedge clk); #1 raw[1] = ~raw[1];
                    repeat ($urandom_range(6, 9)) @(posedge clk);
                end
                repeat (6) @(posedge clk); #1;
                chk("b.ccnt_wrapped", int'(bus_b.o_change_cnt), 5);
                chk("b.dir", int'(bus_b.o_dir), 1);
                for (int r = 0; r < 80; r++) begin
                    @(posedge clk); #1 raw[1] = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
            begin
                for (int r = 0; r < 60; r++) begin
                    @(posedge clk); #1 raw[0] = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(0, 11)) @(posedge clk);
                end
            end
        join
        @(posedge clk); #1 raw = 2'b00;
        repeat (80) @(posedge clk); #1;
        chk("settle.dir_a", int'(bus_a.o_dir), 0);

        // Reset in the middle of a 1 -> 0 guard window.
        @(posedge clk); #1 raw[0] = 1'b1;
        wait_for(S_DIR, 1, 40, at);
        raw[0] = 1'b0;
        wait_for(S_TX, 0, 40, at);
        @(posedge clk);
        @(posedge clk);
        #3 rst_b = 1'b0;
        #1;
        chk("rst.dir", int'(bus_a.o_dir), 0);
        chk("rst.rx", int'(bus_a.o_rx_en), 0);
        chk("rst.tx", int'(bus_a.o_tx_en), 0);
        chk("rst.busy", int'(bus_a.o_busy), 1);
        chk("rst.ccnt", int'(bus_a.o_change_cnt), 0);
        chk("rst.gcnt", int'(bus_a.o_glitch_cnt), 0);
        repeat (3) @(posedge clk);
        #3 rst_b = 1'b1;
        rel = edge_n;
        chg_n = 0; rise = -1000;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chg_n += int'(bus_a.o_dir_changed);
            if (bus_a.o_rx_en && rise < 0) rise = edge_n;
        end
        chk("rst2.rx_rise_delay", rise - rel, 4);
        chk("rst2.no_pulse", chg_n, 0);
        chk("rst2.dir", int'(bus_a.o_dir), 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
